// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package seq_divider_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle for seq_divider: the requester drives start/x/y; the divider returns status and result.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 8
);
  import seq_divider_pkg::*;

  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             val;
  logic             dbz;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;

  modport master (
    output start, x, y,
    input  busy, val, dbz, q, r
  );

  modport slave (
    input  start, x, y,
    output busy, val, dbz, q, r
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift {rem, quo} left, then trial-subtract the divisor.
module div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;
  logic           borrow;

  // rem < divisor on entry, so the shifted remainder needs WIDTH+1 bits and the
  // top bit of the difference is a clean borrow flag.
  assign rem_sh   = {rem, quo[WIDTH-1]};
  assign trial    = rem_sh - {1'b0, divisor};
  assign borrow   = trial[WIDTH];
  assign rem_next = borrow ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned divider, one quotient bit per clock; divide-by-zero flagged without iterating.
// Define DIVIDER_START_ABORT_EN to let start during a division abort it and restart with new operands.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   div_q, div_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               val_q, val_d;
  logic               dbz_q, dbz_d;
  logic               accept;
  logic [WIDTH-1:0]   step_rem;
  logic [WIDTH-1:0]   step_quo;

  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (div_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    dbz_d   = dbz_q;
    accept  = 1'b0;

    unique case (state_q)
      StIdle: begin
        accept = bus.start;
      end
      StRun: begin
`ifdef DIVIDER_START_ABORT_EN
        accept = bus.start;
`endif
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          val_d   = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // An accepted request overrides whatever the current step computed.
    if (accept) begin
      val_d = 1'b0;
      if (bus.y == '0) begin
        dbz_d   = 1'b1;
        state_d = StIdle;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = '0;
      end else begin
        dbz_d   = 1'b0;
        quo_d   = bus.x;
        div_d   = bus.y;
        rem_d   = '0;
        cnt_d   = CntW'(WIDTH);
        state_d = StRun;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      val_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.val  = val_q;
  assign bus.dbz  = dbz_q;
  assign bus.q    = quo_q;
  assign bus.r    = rem_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider at WIDTH=6 against plain integer division.
module tb_seq_divider;

  localparam int unsigned W = 6;

  logic clk = 1'b0;
  logic rst;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(
    .WIDTH(W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Last valid result according to the model; dbz must leave it untouched.
  logic [W-1:0] last_q;
  logic [W-1:0] last_r;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    bus.start = 1'b1;
    bus.x     = x;
    bus.y     = y;
    tick();
    bus.start = 1'b0;
    bus.x     = W'($urandom);
    bus.y     = W'($urandom);
  endtask

  // Issue a request and wait (bounded) for busy to drop; reports edges spent in RUN.
  task automatic run_div(input logic [W-1:0] x, input logic [W-1:0] y,
                         output int cyc, output logic timed_out);
    issue(x, y);
    cyc = 0;
    while (bus.busy && cyc < 2 * W) begin
      tick();
      cyc++;
    end
    timed_out = bus.busy;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.x     = 6'd11;
    bus.y     = 6'd3;
    tick();
    rst       = 1'b0;
    bus.start = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.val !== 1'b0) begin failures++; $display("FAIL reset_val got=%b exp=0", bus.val); end
    checks++; if (bus.dbz !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%b exp=0", bus.dbz); end
    checks++; if (bus.q !== 6'd0) begin failures++; $display("FAIL reset_q got=%0d exp=0", bus.q); end
    checks++; if (bus.r !== 6'd0) begin failures++; $display("FAIL reset_r got=%0d exp=0", bus.r); end
  endtask

  task automatic test_basic();
    logic [W-1:0] x = 6'd11;
    logic [W-1:0] y = 6'd3;
    issue(x, y);
    for (int i = 0; i < int'(W); i++) begin
      checks++;
      if (bus.busy !== 1'b1 || bus.val !== 1'b0) begin
        failures++;
        $display("FAIL basic_run cycle=%0d busy=%b val=%b exp busy=1 val=0", i, bus.busy, bus.val);
      end
      tick();
    end
    last_q = x / y;
    last_r = x % y;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL basic_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.val !== 1'b1) begin failures++; $display("FAIL basic_val got=%b exp=1", bus.val); end
    checks++; if (bus.dbz !== 1'b0) begin failures++; $display("FAIL basic_dbz got=%b exp=0", bus.dbz); end
    checks++; if (bus.q !== last_q) begin failures++; $display("FAIL basic_q got=%0d exp=%0d", bus.q, last_q); end
    checks++; if (bus.r !== last_r) begin failures++; $display("FAIL basic_r got=%0d exp=%0d", bus.r, last_r); end
  endtask

  task automatic test_dbz();
    issue(6'd10, 6'd0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.dbz !== 1'b1 || bus.val !== 1'b0 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL dbz_flags cycle=%0d dbz=%b val=%b busy=%b exp 1/0/0",
                 i, bus.dbz, bus.val, bus.busy);
      end
      checks++;
      if (bus.q !== last_q || bus.r !== last_r) begin
        failures++;
        $display("FAIL dbz_hold q=%0d r=%0d exp q=%0d r=%0d", bus.q, bus.r, last_q, last_r);
      end
      tick();
    end
  endtask

  task automatic test_boundaries();
    logic [W-1:0] xs [6] = '{6'd5, 6'd63, 6'd0, 6'd63, 6'd62, 6'd1};
    logic [W-1:0] ys [6] = '{6'd9, 6'd1, 6'd17, 6'd63, 6'd63, 6'd63};
    int   cyc;
    logic to;
    for (int i = 0; i < 6; i++) begin
      run_div(xs[i], ys[i], cyc, to);
      last_q = xs[i] / ys[i];
      last_r = xs[i] % ys[i];
      checks++;
      if (to || cyc != int'(W)) begin
        failures++;
        $display("FAIL bound_latency x=%0d y=%0d cycles=%0d exp=%0d", xs[i], ys[i], cyc, W);
      end
      checks++;
      if (bus.val !== 1'b1 || bus.dbz !== 1'b0) begin
        failures++;
        $display("FAIL bound_flags x=%0d y=%0d val=%b dbz=%b exp 1/0", xs[i], ys[i], bus.val, bus.dbz);
      end
      checks++;
      if (bus.q !== last_q || bus.r !== last_r) begin
        failures++;
        $display("FAIL bound_result x=%0d y=%0d q=%0d r=%0d exp q=%0d r=%0d",
                 xs[i], ys[i], bus.q, bus.r, last_q, last_r);
      end
    end
  endtask

  task automatic test_busy_start();
    int remaining;
    issue(6'd50, 6'd7);
    tick();
    tick();
    issue(6'd20, 6'd4);
`ifdef DIVIDER_START_ABORT_EN
    last_q    = 6'd20 / 6'd4;
    last_r    = 6'd20 % 6'd4;
    remaining = int'(W);
`else
    last_q    = 6'd50 / 6'd7;
    last_r    = 6'd50 % 6'd7;
    remaining = int'(W) - 3;
`endif
    for (int i = 0; i < remaining; i++) begin
      checks++;
      if (bus.busy !== 1'b1 || bus.val !== 1'b0) begin
        failures++;
        $display("FAIL busy_start_run cycle=%0d busy=%b val=%b exp busy=1 val=0", i, bus.busy, bus.val);
      end
      tick();
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.val !== 1'b1) begin
      failures++;
      $display("FAIL busy_start_done busy=%b val=%b exp busy=0 val=1", bus.busy, bus.val);
    end
    checks++;
    if (bus.q !== last_q || bus.r !== last_r) begin
      failures++;
      $display("FAIL busy_start_result q=%0d r=%0d exp q=%0d r=%0d", bus.q, bus.r, last_q, last_r);
    end
  endtask

  task automatic test_reset_mid_run();
    int   cyc;
    logic to;
    issue(6'd45, 6'd6);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.val !== 1'b0 || bus.dbz !== 1'b0) begin
      failures++;
      $display("FAIL midreset_flags busy=%b val=%b dbz=%b exp 0/0/0", bus.busy, bus.val, bus.dbz);
    end
    checks++;
    if (bus.q !== 6'd0 || bus.r !== 6'd0) begin
      failures++;
      $display("FAIL midreset_qr q=%0d r=%0d exp 0/0", bus.q, bus.r);
    end
    run_div(6'd45, 6'd6, cyc, to);
    checks++;
    if (to || bus.val !== 1'b1 || bus.q !== 6'd7 || bus.r !== 6'd3) begin
      failures++;
      $display("FAIL midreset_fresh val=%b q=%0d r=%0d exp val=1 q=7 r=3", bus.val, bus.q, bus.r);
    end
  endtask

  // Every (x, y != 0) pair, x scrambled by a random mask, issued back to back.
  task automatic test_sweep();
    logic [W-1:0] mask;
    logic [W-1:0] x;
    int           cyc;
    logic         to;
    mask = W'($urandom_range(0, 63));
    for (int xi = 0; xi < 64; xi++) begin
      for (int yi = 1; yi < 64; yi++) begin
        x = W'(xi) ^ mask;
        run_div(x, W'(yi), cyc, to);
        checks++;
        if (to || bus.val !== 1'b1 || cyc != int'(W)) begin
          failures++;
          $display("FAIL sweep_done x=%0d y=%0d val=%b cycles=%0d exp val=1 cycles=%0d",
                   x, yi, bus.val, cyc, W);
        end
        checks++;
        if (int'(bus.q) * yi + int'(bus.r) != int'(x) || int'(bus.r) >= yi) begin
          failures++;
          $display("FAIL sweep_identity x=%0d y=%0d q=%0d r=%0d", x, yi, bus.q, bus.r);
        end
        checks++;
        if (int'(bus.q) != int'(x) / yi) begin
          failures++;
          $display("FAIL sweep_q x=%0d y=%0d q=%0d exp=%0d", x, yi, bus.q, int'(x) / yi);
        end
      end
    end
  endtask

  initial begin
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.x     = '0;
    bus.y     = '0;
    last_q    = '0;
    last_r    = '0;
    test_reset();
    test_basic();
    test_dbz();
    test_boundaries();
    test_busy_start();
    test_reset_mid_run();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
